program_feeder: RTL and testbench

PROGRAM_FEEDER -- requirements
Module: program_feeder

---
 rtl/program_feeder_if.sv | 39 +++
 rtl/program_feeder.sv | 185 ++++++++++++++++++
 tb/tb_program_feeder.sv | 321 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/program_feeder_if.sv
// program_feeder_if: handshake/status bundle between a program source
// (switches/buttons or a testbench) and the program_feeder block.
//   SW_data, Load, Start, Clear : program load and playback controls
//   Done                        : instruction-complete from the processor
//   DIN, Run                    : word and issue strobe to the processor
//   Count, PC                   : words loaded / playback read pointer
//   Busy, Halted, Full, Error   : status flags
// DEPTH must match the DEPTH of the program_feeder it connects to.
interface program_feeder_if #(
  parameter int DEPTH = 16
) ();
  localparam int AW = $clog2(DEPTH);

  logic [15:0] SW_data;
  logic        Load;
  logic        Start;
  logic        Clear;
  logic        Done;
  logic [15:0] DIN;
  logic        Run;
  logic [AW:0] Count;
  logic [AW-1:0] PC;
  logic        Busy;
  logic        Halted;
  logic        Full;
  logic        Error;

  // Source side: drives controls, observes feeder outputs.
  modport master (
    output SW_data, Load, Start, Clear, Done,
    input  DIN, Run, Count, PC, Busy, Halted, Full, Error
  );

  // Feeder side.
  modport slave (
    input  SW_data, Load, Start, Clear, Done,
    output DIN, Run, Count, PC, Busy, Halted, Full, Error
  );
endinterface

// File: rtl/program_feeder.sv
// program_feeder: small program buffer that is filled word by word and then
// played back to a processor one instruction at a time.
//   Clock  : single rising-edge clock
//   Resetn : asynchronous active-low reset
//   bus    : program_feeder_if.slave (see interface for signal list)
// Words at or beyond Count read as 16'h0000. An instruction whose opcode
// field [8:6] equals MVI_OPCODE consumes the following word as its
// immediate, which stays on DIN while waiting for Done.
module program_feeder #(
  parameter int         DEPTH      = 16,
  parameter logic [2:0] MVI_OPCODE = 3'b001,
  parameter int         TIMEOUT    = 255
) (
  input logic            Clock,
  input logic            Resetn,
  program_feeder_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [AW:0]   DEPTH_W = (AW + 1)'(DEPTH);
  localparam logic [AW-1:0] PC_MAX  = AW'(DEPTH - 1);
  localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT - 1);
  localparam logic [AW:0]   ONE_W   = (AW + 1)'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    HALT  = 2'd3
  } state_t;

  state_t        state_r;
  logic [15:0]   mem_r [DEPTH];
  logic [AW:0]   count_r;
  // One bit wider than PC so "past the last word" is representable.
  logic [AW:0]   ptr_r;
  logic [2:0]    opcode_r;
  logic [WW-1:0] wdog_r;
  logic          run_r;
  logic          error_r;
  logic [15:0]   din_r;
  logic          load_q_r;
  logic          start_q_r;

  logic          load_edge_s;
  logic          start_edge_s;
  logic          full_s;
  logic          mem_we_s;
  logic [AW:0]   ptr_inc_s;
  logic [AW:0]   next_ptr_s;
  logic [15:0]   rd_first_s;
  logic [15:0]   rd_cur_s;
  logic [15:0]   rd_inc_s;
  logic [15:0]   rd_next_s;

  // Buffer read that returns zero for any word not yet loaded.
  function automatic logic [15:0] read_word(input logic [AW:0] idx,
                                            input logic [AW:0] cnt);
    if (idx < cnt) begin
      return mem_r[idx[AW-1:0]];
    end else begin
      return 16'h0000;
    end
  endfunction

  assign load_edge_s  = bus.Load  & ~load_q_r;
  assign start_edge_s = bus.Start & ~start_q_r;
  assign full_s       = (count_r == DEPTH_W);
  // Start and Clear both pre-empt a Load arriving in the same cycle.
  assign mem_we_s     = (state_r == IDLE) & load_edge_s & ~start_edge_s &
                        ~bus.Clear & ~full_s;
  assign ptr_inc_s    = ptr_r + ONE_W;
  assign next_ptr_s   = (opcode_r == MVI_OPCODE) ? ptr_inc_s : ptr_r;
  assign rd_first_s   = read_word({(AW + 1){1'b0}}, count_r);
  assign rd_cur_s     = read_word(ptr_r, count_r);
  assign rd_inc_s     = read_word(ptr_inc_s, count_r);
  assign rd_next_s    = read_word(next_ptr_s, count_r);

  assign bus.DIN    = din_r;
  assign bus.Run    = run_r;
  assign bus.Count  = count_r;
  // After the last of DEPTH words the internal pointer reaches DEPTH;
  // the visible PC saturates instead of wrapping to zero.
  assign bus.PC     = (ptr_r >= DEPTH_W) ? PC_MAX : ptr_r[AW-1:0];
  assign bus.Busy   = (state_r == ISSUE) | (state_r == WAIT);
  assign bus.Halted = (state_r == HALT);
  assign bus.Full   = full_s;
  assign bus.Error  = error_r;

  // Registered copies of Load/Start for single-shot edge detection.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      load_q_r  <= 1'b0;
      start_q_r <= 1'b0;
    end else begin
      load_q_r  <= bus.Load;
      start_q_r <= bus.Start;
    end
  end

  // Program buffer write port; contents deliberately survive reset.
  always_ff @(posedge Clock) begin
    if (mem_we_s) begin
      mem_r[count_r[AW-1:0]] <= bus.SW_data;
    end
  end

  // Playback FSM with registered Run/DIN/Error.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_r  <= IDLE;
      count_r  <= '0;
      ptr_r    <= '0;
      opcode_r <= 3'b000;
      wdog_r   <= '0;
      run_r    <= 1'b0;
      error_r  <= 1'b0;
      din_r    <= 16'h0000;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.Clear) begin
            count_r <= '0;
            ptr_r   <= '0;
            error_r <= 1'b0;
            din_r   <= 16'h0000;
          end else if (start_edge_s) begin
            if (count_r != '0) begin
              ptr_r   <= '0;
              run_r   <= 1'b1;
              din_r   <= rd_first_s;
              state_r <= ISSUE;
            end
          end else if (load_edge_s && !full_s) begin
            count_r <= count_r + ONE_W;
          end
        end
        ISSUE: begin
          run_r    <= 1'b0;
          opcode_r <= rd_cur_s[8:6];
          ptr_r    <= ptr_inc_s;
          din_r    <= rd_inc_s;
          wdog_r   <= '0;
          state_r  <= WAIT;
        end
        WAIT: begin
          if (bus.Done) begin
            ptr_r <= next_ptr_s;
            if (next_ptr_s >= count_r) begin
              state_r <= HALT;
            end else begin
              run_r   <= 1'b1;
              din_r   <= rd_next_s;
              state_r <= ISSUE;
            end
          end else if (wdog_r == WD_LAST) begin
            error_r <= 1'b1;
            state_r <= HALT;
          end else begin
            wdog_r <= wdog_r + WW'(1);
          end
        end
        HALT: begin
          if (bus.Clear) begin
            count_r <= '0;
            ptr_r   <= '0;
            error_r <= 1'b0;
            din_r   <= 16'h0000;
            state_r <= IDLE;
          end else if (start_edge_s) begin
            error_r <= 1'b0;
            ptr_r   <= '0;
            run_r   <= 1'b1;
            din_r   <= rd_first_s;
            state_r <= ISSUE;
          end
        end
        default: begin
          run_r   <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_program_feeder.sv
// Self-checking bench for program_feeder. Every Run pulse is checked by a
// monitor against a queue of expected issued words that the scenario tasks
// fill before starting playback.
module tb_program_feeder;
  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  logic [15:0] exp_q[$];

  program_feeder_if #(.DEPTH(16)) bus ();

  program_feeder #(.DEPTH(16), .MVI_OPCODE(3'b001), .TIMEOUT(255)) dut (
    .Clock (clk),
    .Resetn(rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: each issue strobe must match the next expected word.
  always @(negedge clk) begin
    if (rst_n && bus.Run) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL run_unexpected: DIN=%h with no issue expected", bus.DIN);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        if (bus.DIN !== e) begin
          bad++;
          $display("FAIL run_din: got %h want %h", bus.DIN, e);
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [15:0] w);
    bus.SW_data = w;
    bus.Load = 1'b1;
    tick();
    bus.Load = 1'b0;
    tick();
  endtask

  task automatic do_start;
    bus.Start = 1'b1;
    tick();
    bus.Start = 1'b0;
  endtask

  task automatic do_done;
    bus.Done = 1'b1;
    tick();
    bus.Done = 1'b0;
  endtask

  task automatic do_clear;
    bus.Clear = 1'b1;
    tick();
    bus.Clear = 1'b0;
    tick();
  endtask

  task automatic test_reset;
    bus.SW_data = 16'hA5A5;
    bus.Load = 1'b1;
    #2 rst_n = 1'b0;
    tick();
    tick();
    total++;
    if ({bus.Run, bus.Busy, bus.Halted, bus.Error, bus.Full} !== 5'b00000 ||
        bus.DIN !== 16'h0000 || bus.Count !== 5'd0 || bus.PC !== 4'd0) begin
      bad++;
      $display("FAIL reset_state: run=%b busy=%b halt=%b err=%b full=%b din=%h cnt=%0d pc=%0d want all zero",
               bus.Run, bus.Busy, bus.Halted, bus.Error, bus.Full, bus.DIN, bus.Count, bus.PC);
    end
    rst_n = 1'b1;
    tick();
    total++;
    if (bus.Count !== 5'd1) begin
      bad++;
      $display("FAIL reset_held_load: Count=%0d want 1", bus.Count);
    end
    bus.Load = 1'b0;
    tick();
    do_clear();
    total++;
    if (bus.Count !== 5'd0) begin
      bad++;
      $display("FAIL reset_clear: Count=%0d want 0", bus.Count);
    end
  endtask

  task automatic test_two_instr;
    do_load(16'h0008);
    do_load(16'h0081);
    total++;
    if (bus.Count !== 5'd2) begin
      bad++;
      $display("FAIL two_count: Count=%0d want 2", bus.Count);
    end
    exp_q.push_back(16'h0008);
    do_start();
    total++;
    if (bus.Busy !== 1'b1 || bus.Run !== 1'b1) begin
      bad++;
      $display("FAIL two_issue: busy=%b run=%b want 1 1", bus.Busy, bus.Run);
    end
    tick();
    total++;
    if (bus.Run !== 1'b0 || bus.DIN !== 16'h0081) begin
      bad++;
      $display("FAIL two_wait: run=%b din=%h want 0 0081", bus.Run, bus.DIN);
    end
    bus.Clear = 1'b1;
    tick();
    bus.Clear = 1'b0;
    tick();
    tick();
    total++;
    if (bus.Busy !== 1'b1 || bus.Count !== 5'd2 || bus.Halted !== 1'b0) begin
      bad++;
      $display("FAIL two_hold: busy=%b cnt=%0d halt=%b want 1 2 0", bus.Busy, bus.Count, bus.Halted);
    end
    exp_q.push_back(16'h0081);
    do_done();
    total++;
    if (bus.PC !== 4'd1 || bus.Run !== 1'b1) begin
      bad++;
      $display("FAIL two_second_issue: pc=%0d run=%b want 1 1", bus.PC, bus.Run);
    end
    tick();
    do_done();
    total++;
    if (bus.Halted !== 1'b1 || bus.PC !== 4'd2 || bus.Busy !== 1'b0 || bus.Error !== 1'b0) begin
      bad++;
      $display("FAIL two_halt: halt=%b pc=%0d busy=%b err=%b want 1 2 0 0",
               bus.Halted, bus.PC, bus.Busy, bus.Error);
    end
  endtask

  task automatic test_mvi;
    do_clear();
    total++;
    if (bus.Count !== 5'd0 || bus.Halted !== 1'b0 || bus.DIN !== 16'h0000) begin
      bad++;
      $display("FAIL mvi_clear: cnt=%0d halt=%b din=%h want 0 0 0000", bus.Count, bus.Halted, bus.DIN);
    end
    do_load(16'h0040);
    do_load(16'h1234);
    exp_q.push_back(16'h0040);
    do_start();
    tick();
    total++;
    if (bus.DIN !== 16'h1234 || bus.Run !== 1'b0) begin
      bad++;
      $display("FAIL mvi_imm: din=%h run=%b want 1234 0", bus.DIN, bus.Run);
    end
    do_done();
    tick();
    total++;
    if (bus.Halted !== 1'b1 || bus.PC !== 4'd2 || exp_q.size() != 0) begin
      bad++;
      $display("FAIL mvi_halt: halt=%b pc=%0d pending=%0d want 1 2 0", bus.Halted, bus.PC, exp_q.size());
    end
  endtask

  task automatic test_full;
    do_clear();
    for (int i = 0; i < 17; i++) begin
      do_load(16'h0100 + 16'(i));
    end
    total++;
    if (bus.Count !== 5'd16 || bus.Full !== 1'b1) begin
      bad++;
      $display("FAIL full_count: cnt=%0d full=%b want 16 1", bus.Count, bus.Full);
    end
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back(16'h0100 + 16'(i));
    end
    do_start();
    for (int i = 0; i < 16; i++) begin
      tick();
      do_done();
    end
    total++;
    if (bus.Halted !== 1'b1 || bus.PC !== 4'd15 || exp_q.size() != 0) begin
      bad++;
      $display("FAIL full_playback: halt=%b pc=%0d pending=%0d want 1 15 0", bus.Halted, bus.PC, exp_q.size());
    end
    do_clear();
    total++;
    if (bus.Count !== 5'd0 || bus.Full !== 1'b0) begin
      bad++;
      $display("FAIL full_clear: cnt=%0d full=%b want 0 0", bus.Count, bus.Full);
    end
  endtask

  task automatic test_timeout;
    int cnt;
    do_load(16'h0008);
    exp_q.push_back(16'h0008);
    do_start();
    cnt = 1;
    for (int i = 0; i < 400; i++) begin
      tick();
      if (!bus.Busy) break;
      cnt++;
    end
    total++;
    if (cnt != 256 || bus.Error !== 1'b1 || bus.Halted !== 1'b1) begin
      bad++;
      $display("FAIL timeout: busy_cycles=%0d err=%b halt=%b want 256 1 1", cnt, bus.Error, bus.Halted);
    end
    exp_q.push_back(16'h0008);
    do_start();
    total++;
    if (bus.Error !== 1'b0 || bus.Run !== 1'b1) begin
      bad++;
      $display("FAIL timeout_replay: err=%b run=%b want 0 1", bus.Error, bus.Run);
    end
    tick();
    do_done();
    total++;
    if (bus.Halted !== 1'b1 || bus.Error !== 1'b0) begin
      bad++;
      $display("FAIL timeout_done: halt=%b err=%b want 1 0", bus.Halted, bus.Error);
    end
  endtask

  task automatic test_empty_start;
    do_clear();
    do_start();
    tick();
    tick();
    total++;
    if (bus.Busy !== 1'b0 || bus.Halted !== 1'b0 || bus.Count !== 5'd0) begin
      bad++;
      $display("FAIL empty_start: busy=%b halt=%b cnt=%0d want 0 0 0", bus.Busy, bus.Halted, bus.Count);
    end
  endtask

  task automatic test_back_to_back;
    do_load(16'h0008);
    bus.SW_data = 16'h0077;
    bus.Load = 1'b1;
    bus.Start = 1'b1;
    exp_q.push_back(16'h0008);
    tick();
    bus.Load = 1'b0;
    bus.Start = 1'b0;
    total++;
    if (bus.Busy !== 1'b1 || bus.Count !== 5'd1) begin
      bad++;
      $display("FAIL same_cycle: busy=%b cnt=%0d want 1 1", bus.Busy, bus.Count);
    end
    tick();
    do_done();
    total++;
    if (bus.Halted !== 1'b1 || bus.Count !== 5'd1 || bus.PC !== 4'd1) begin
      bad++;
      $display("FAIL same_cycle_halt: halt=%b cnt=%0d pc=%0d want 1 1 1", bus.Halted, bus.Count, bus.PC);
    end
  endtask

  task automatic test_reset_mid_wait;
    do_clear();
    do_load(16'h0008);
    do_load(16'h0081);
    exp_q.push_back(16'h0008);
    do_start();
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({bus.Run, bus.Busy, bus.Halted, bus.Error} !== 4'b0000 ||
        bus.DIN !== 16'h0000 || bus.Count !== 5'd0 || bus.PC !== 4'd0) begin
      bad++;
      $display("FAIL reset_mid_wait: run=%b busy=%b halt=%b err=%b din=%h cnt=%0d pc=%0d want all zero",
               bus.Run, bus.Busy, bus.Halted, bus.Error, bus.DIN, bus.Count, bus.PC);
    end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst_n = 1'b1;
    bus.SW_data = 16'h0000;
    bus.Load = 1'b0;
    bus.Start = 1'b0;
    bus.Clear = 1'b0;
    bus.Done = 1'b0;
    test_reset();
    test_two_instr();
    test_mvi();
    test_full();
    test_timeout();
    test_empty_start();
    test_back_to_back();
    test_reset_mid_wait();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL pending_issues: %0d expected words never issued, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
